// File: rtl/effect_pkg.sv
// Shared constants for the effect control stage and the 7-segment effect engines.
package effect_pkg;

  localparam int unsigned CHAR_W = 7;

  localparam logic [2:0] EN_EFFECT1 = 3'b001;
  localparam logic [2:0] EN_EFFECT2 = 3'b010;
  localparam logic [2:0] EN_EFFECT3 = 3'b100;

  localparam logic [1:0] FREQ_05HZ = 2'b00;
  localparam logic [1:0] FREQ_1HZ  = 2'b01;
  localparam logic [1:0] FREQ_2HZ  = 2'b10;
  localparam logic [1:0] FREQ_4HZ  = 2'b11;

  localparam logic [CHAR_W-1:0] BLANK_CHAR_DEF = 7'h20;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250_000;
  localparam int unsigned AUTO_PERIOD_DEF     = 250_000_000;

  // Step periods in 25 MHz clk cycles for each speed code.
  localparam int unsigned PERIOD_05HZ = 50_000_000;
  localparam int unsigned PERIOD_1HZ  = 25_000_000;
  localparam int unsigned PERIOD_2HZ  = 12_500_000;
  localparam int unsigned PERIOD_4HZ  = 6_250_000;

  function automatic logic [2:0] rotate_en(input logic [2:0] en);
    return {en[1:0], en[2]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and single-cycle press pulse for one active-low button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync2 != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync1   <= btn_n;
      sync2   <= sync1;
      // Only an accepted release-to-press transition produces an event.
      pressed <= accept && !sync2;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/effect_ctrl.sv
// Effect select, speed code and message register feeding the effect engines.
// Optional idle auto-advance of the effect select: EFFECT_AUTO_CYCLE_EN.
module effect_ctrl
  import effect_pkg::*;
#(
  parameter int unsigned        DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [CHAR_W-1:0]  BLANK_CHAR      = BLANK_CHAR_DEF
`ifdef EFFECT_AUTO_CYCLE_EN
  ,
  parameter int unsigned        AUTO_PERIOD     = AUTO_PERIOD_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_mode,
  input  logic              btn_speed,
  input  logic              char_wr,
  input  logic [CHAR_W-1:0] char_in,
  output logic [2:0]        enable,
  output logic [1:0]        frequency,
  output logic [CHAR_W-1:0] char0,
  output logic [CHAR_W-1:0] char1,
  output logic [CHAR_W-1:0] char2,
  output logic [CHAR_W-1:0] char3,
  output logic [CHAR_W-1:0] char4,
  output logic [CHAR_W-1:0] char5,
  output logic [CHAR_W-1:0] char6
);

  logic mode_ev;
  logic speed_ev;
  logic rotate;
  logic [CHAR_W-1:0] msg [7];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_mode),
    .pressed (mode_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_speed),
    .pressed (speed_ev)
  );

`ifdef EFFECT_AUTO_CYCLE_EN
  localparam logic [27:0] AUTO_LAST = 28'(AUTO_PERIOD - 1);

  logic [27:0] idle_timer;
  logic        auto_hit;

  assign auto_hit = (idle_timer == AUTO_LAST);
  // OR-ing the two causes keeps a coinciding press and expiry to a single rotation.
  assign rotate   = mode_ev || auto_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_timer <= '0;
    end else if (mode_ev || speed_ev || auto_hit) begin
      idle_timer <= '0;
    end else begin
      idle_timer <= idle_timer + 28'd1;
    end
  end
`else
  assign rotate = mode_ev;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable    <= EN_EFFECT1;
      frequency <= FREQ_1HZ;
    end else begin
      if (rotate) begin
        enable <= rotate_en(enable);
      end
      if (speed_ev) begin
        frequency <= frequency + 2'd1;
      end
    end
  end

  // char_wr is a one-cycle strobe with no back-pressure; each asserted cycle shifts in one character.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 7; k++) begin
        msg[k] <= BLANK_CHAR;
      end
    end else if (char_wr) begin
      for (int k = 0; k < 6; k++) begin
        msg[k] <= msg[k+1];
      end
      msg[6] <= char_in;
    end
  end

  assign char0 = msg[0];
  assign char1 = msg[1];
  assign char2 = msg[2];
  assign char3 = msg[3];
  assign char4 = msg[4];
  assign char5 = msg[5];
  assign char6 = msg[6];

endmodule

// File: tb/tb_effect_ctrl.sv
// Directed bench for effect_ctrl with a short debounce window.
module tb_effect_ctrl;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b1;
  logic       btn_speed = 1'b1;
  logic       char_wr = 1'b0;
  logic [6:0] char_in = 7'h00;
  logic [2:0] enable;
  logic [1:0] frequency;
  logic [6:0] char0, char1, char2, char3, char4, char5, char6;

  int pass_cnt = 0;
  int total_cnt = 0;
  int en_changes = 0;
  logic [2:0] en_prev = 3'b001;

  typedef struct {
    string      name;
    int         mode_len;
    int         speed_len;
    logic [2:0] exp_en;
    logic [1:0] exp_freq;
  } vec_t;

  vec_t vecs [8];
  logic [6:0] exp_q [$];

  effect_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .BLANK_CHAR      (7'h20)
`ifdef EFFECT_AUTO_CYCLE_EN
    ,
    .AUTO_PERIOD     (16)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_mode  (btn_mode),
    .btn_speed (btn_speed),
    .char_wr   (char_wr),
    .char_in   (char_in),
    .enable    (enable),
    .frequency (frequency),
    .char0     (char0),
    .char1     (char1),
    .char2     (char2),
    .char3     (char3),
    .char4     (char4),
    .char5     (char5),
    .char6     (char6)
  );

  // Clock and reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (enable !== en_prev) en_changes++;
    en_prev = enable;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic press(input int ml, input int sl);
    int n;
    n = (ml > sl) ? ml : sl;
    for (int i = 0; i < n; i++) begin
      btn_mode  = (i < ml) ? 1'b0 : 1'b1;
      btn_speed = (i < sl) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    btn_mode  = 1'b1;
    btn_speed = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic write_char(input logic [6:0] c);
    char_wr = 1'b1;
    char_in = c;
    exp_q.push_back(c);
    void'(exp_q.pop_front());
    @(negedge clk);
    char_wr = 1'b0;
  endtask

  task automatic check_chars(input string tag);
    check({tag, " char0"}, char0, exp_q[0]);
    check({tag, " char1"}, char1, exp_q[1]);
    check({tag, " char2"}, char2, exp_q[2]);
    check({tag, " char3"}, char3, exp_q[3]);
    check({tag, " char4"}, char4, exp_q[4]);
    check({tag, " char5"}, char5, exp_q[5]);
    check({tag, " char6"}, char6, exp_q[6]);
  endtask

  initial begin
    int base;
    vecs[0] = '{"mode->100",      20, 0,  3'b100, 2'b01};
    vecs[1] = '{"mode->001",      20, 0,  3'b001, 2'b01};
    vecs[2] = '{"speed->10",      0,  20, 3'b001, 2'b10};
    vecs[3] = '{"speed->11",      0,  20, 3'b001, 2'b11};
    vecs[4] = '{"speed wrap->00", 0,  20, 3'b001, 2'b00};
    vecs[5] = '{"speed->01",      0,  20, 3'b001, 2'b01};
    vecs[6] = '{"speed glitch",   0,  3,  3'b001, 2'b01};
    vecs[7] = '{"both",           20, 20, 3'b010, 2'b10};
    for (int k = 0; k < 7; k++) exp_q.push_back(7'h20);

    repeat (3) @(negedge clk);
    check("reset en held", enable, 3'b001);
    check("reset freq held", frequency, 2'b01);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset en", enable, 3'b001);
    check("reset freq", frequency, 2'b01);
    check_chars("reset");

`ifdef EFFECT_AUTO_CYCLE_EN
    // Release was at a negedge: the 16th following edge expires the timer.
    repeat (14) @(posedge clk);
    #1 check("auto before 1st", enable, 3'b001);
    @(posedge clk);
    #1 check("auto 1st", enable, 3'b010);
    @(negedge clk);
    btn_mode = 1'b0;
    repeat (DEB + 2) @(posedge clk);
    #1 check("auto press pending", enable, 3'b010);
    @(posedge clk);
    #1 check("auto press", enable, 3'b100);
    repeat (15) @(posedge clk);
    #1 check("auto after press -1", enable, 3'b100);
    @(posedge clk);
    #1 check("auto after press", enable, 3'b001);
    btn_mode = 1'b1;
`else
    press(3, 0);
    check("mode glitch", enable, 3'b001);

    // Latency: event lands on edge DEB+3 after the first low sample.
    base = en_changes;
    btn_mode = 1'b0;
    repeat (DEB + 2) @(posedge clk);
    #1 check("latency early", enable, 3'b001);
    @(posedge clk);
    #1 check("latency edge", enable, 3'b010);
    @(negedge clk);
    repeat (13) @(negedge clk);
    btn_mode = 1'b1;
    repeat (12) @(negedge clk);
    check("held one change", en_changes - base, 1);

    for (int v = 0; v < 8; v++) begin
      press(vecs[v].mode_len, vecs[v].speed_len);
      check({vecs[v].name, " en"}, enable, vecs[v].exp_en);
      check({vecs[v].name, " freq"}, frequency, vecs[v].exp_freq);
    end

    write_char(7'h55);
    // Reset mid-count must clear outputs without a clock edge.
    btn_mode = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst en", enable, 3'b001);
    check("async rst freq", frequency, 2'b01);
    check("async rst char6", char6, 7'h20);
    exp_q.delete();
    for (int k = 0; k < 7; k++) exp_q.push_back(7'h20);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("held thru reset en", enable, 3'b010);
    btn_mode = 1'b1;
    repeat (12) @(negedge clk);
    check("held thru reset release", enable, 3'b010);

    for (int k = 0; k < 7; k++) write_char(7'h41 + 7'(k));
    check_chars("msg7");
    write_char(7'h48);
    check_chars("msg8");
    check("msg8 char0 lit", char0, 7'h42);
    check("msg8 char6 lit", char6, 7'h48);

    base = en_changes;
    repeat (100) @(negedge clk);
    check("idle no rotate", en_changes - base, 0);
    check("idle en", enable, 3'b010);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/effect_ctrl.md
Name: effect_ctrl

Overview:
- Control stage directly upstream of the 7-segment effect engines. It drives the `enable` (effect select), `frequency` (speed code) and `char0..char6` buses that those engines consume.
- It debounces two raw push-buttons: MODE and SPEED.
- It steps the effect select and speed code on each debounced press.
- It holds a 7-character message register, loaded by a scroll-in write strobe.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles needed to accept a button level change (10 ms at 25 MHz).
- BLANK_CHAR, 7'h20: character code loaded into every message slot at reset.
- AUTO_PERIOD, 250000000: idle cycles before an automatic effect advance (10 s at 25 MHz). Used only with EFFECT_AUTO_CYCLE_EN.

Ports:
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  reset, asynchronous assert, active-low.
- btn_mode  in  1  raw MODE button, active-low, asynchronous to clk.
- btn_speed  in  1  raw SPEED button, active-low, asynchronous to clk.
- char_wr  in  1  single-cycle strobe that writes one character.
- char_in  in  7  character code written on char_wr.
- enable  out  3  one-hot effect select: 3'b001, 3'b010 or 3'b100.
- frequency  out  2  speed code: 00=0.5 Hz, 01=1 Hz, 10=2 Hz, 11=4 Hz.
- char0..char6  out  7 each  message characters; char0 is the leftmost digit.

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
  - While rst_n=0: enable=3'b001, frequency=2'b01, char0..char6=BLANK_CHAR.
  - Also while rst_n=0: synchronisers=1, debounced levels=released(1), debounce counters=0, auto timer=0.
  - Reset may assert at any cycle; all state clears immediately.
- Button path, per button, identical logic:
  - Two-flop synchroniser.
  - Debounce counter increments while the synced level differs from the debounced level.
  - The counter clears on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the synced value and the counter clears.
  - A press event is a 1-cycle pulse, registered on the debounced 1->0 transition. Release generates no event.
- Latency: a clean raw falling edge changes enable/frequency on the (DEBOUNCE_CYCLES+3)th rising clk edge after the first edge that samples the low level.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES cycles produces no event.
- Held button: exactly one event per press, with no auto-repeat.
- Held through reset release: the button yields one press event after debounce.
- MODE event: enable rotates 001 -> 010 -> 100 -> 001.
- SPEED event: frequency increments by 1, wrapping 11 -> 00.
- Simultaneous MODE and SPEED events in the same cycle: both apply in that cycle.
- Message write, on a char_wr cycle:
  - char6 <= char_in.
  - char_k <= char_k+1 for k=0..5, so the old char0 is discarded.
  - The outputs show the new values after that edge.
  - char_wr on consecutive cycles shifts once per cycle.
  - char_wr is independent of button events; both may occur in the same cycle.
- Output stability:
  - All outputs are registered.
  - enable is never all-zero and never multi-hot, including after reset.
  - frequency changes only on SPEED events.

Optional Feature:
- Macro: EFFECT_AUTO_CYCLE_EN.
- When defined:
  - A 28-bit idle timer increments every cycle.
  - At AUTO_PERIOD-1 the timer clears and enable rotates exactly as for a MODE event.
  - Any MODE or SPEED event clears the timer.
  - A MODE event coinciding with auto expiry rotates enable once only, not twice.
- When undefined:
  - No timer logic exists; enable changes only on MODE events.

Decomposition:
- Package effect_pkg holds:
  - EN_EFFECT1/EN_EFFECT2/EN_EFFECT3 (3'b001/010/100).
  - FREQ_05HZ/FREQ_1HZ/FREQ_2HZ/FREQ_4HZ codes.
  - CHAR_W=7 and BLANK_CHAR default.
  - The period constants shared with the effect engines.
- Sub-module btn_debounce contains the synchroniser, counter and press pulse.
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, rst_n, btn_n, pressed (pulse).
  - Instantiated twice.

Test Plan:
- Reset check, DEBOUNCE_CYCLES=4: hold rst_n=0, then release -> enable=001, frequency=01, all chars=7'h20. Assert rst_n mid-count -> outputs return to reset values at once, with no clock edge needed.
- Debounce: btn_mode low for 3 cycles, then high -> enable stays 001. Low for 20 cycles -> enable=010 on edge 7 after the first low sample, with exactly one change.
- Wrap: 4 SPEED presses from reset -> frequency 10, 11, 00, 01. 3 MODE presses -> 010, 100, 001.
- Simultaneous: both buttons pressed on the same cycle -> enable and frequency step on the same edge.
- Message: write 7'h41..7'h47 on 7 consecutive char_wr cycles -> char0=41 … char6=47. One more write of 7'h48 -> char0=42, char6=48.
- Auto cycle, AUTO_PERIOD=16, macro on: idle -> enable rotates every 16 cycles. MODE press at cycle 10 -> next auto rotation 16 cycles after the press. Macro off: no rotation over 100 idle cycles.
